// File: rtl/mkio_rt_tx_if.sv
// MKIO RT transmit-path bus bundle: command in, encoder handshake out,
// RT memory read port. The RT block uses the slave view, the surrounding
// decoder/encoder/memory environment uses the master view.
interface mkio_rt_tx_if;
    logic        start;
    logic [15:0] rx_data;
    logic        p_error;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        tx_busy;
    logic [4:0]  addr_rd;
    logic        rd_en;
    logic [15:0] mem_data;
    logic        busy;

    modport slave (
        input  start, rx_data, p_error, tx_busy, mem_data,
        output tx_data, tx_cd, tx_ready, addr_rd, rd_en, busy
    );

    modport master (
        output start, rx_data, p_error, tx_busy, mem_data,
        input  tx_data, tx_cd, tx_ready, addr_rd, rd_en, busy
    );
endinterface

// File: rtl/mkio_rt_tx.sv
// MKIO (MIL-STD-1553) remote terminal transmit path.
// On a transmit command addressed to this RT it sends the status word and
// then N data words read from RT memory, one word per encoder handshake.
// Optional build macro: MKIO_TX_RESP_DELAY_EN inserts RESP_DELAY idle
// cycles between command decode and status word load.
module mkio_rt_tx #(
    parameter logic [4:0] ADDRESS    = 5'd1,
    parameter int         RESP_DELAY = 8
) (
    input logic         clk,
    input logic         reset,
    mkio_rt_tx_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
`ifdef MKIO_TX_RESP_DELAY_EN
        DELAY,
`endif
        LOAD_SW,
        PULSE,
        GUARD,
        WAIT_TX,
        RD_MEM,
        LOAD_DW
    } state_t;

    state_t      state;
    logic        cmd_ok;
    logic        me;
    logic [5:0]  n_words;
    logic [5:0]  word_cnt;
`ifdef MKIO_TX_RESP_DELAY_EN
    logic [7:0]  dly_cnt;
`endif

    logic        cmd_match;
    logic [5:0]  cmd_words;

    // Command field decode; a zero word count field means 32 words.
    assign cmd_match = (bus.rx_data[15:11] == ADDRESS) && bus.rx_data[10];
    assign cmd_words = (bus.rx_data[4:0] == 5'd0) ? 6'd32 : {1'b0, bus.rx_data[4:0]};

    // Response sequencer; a start pulse in any state restarts the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cmd_ok       <= 1'b0;
            me           <= 1'b0;
            n_words      <= 6'd0;
            word_cnt     <= 6'd0;
            bus.tx_data  <= 16'd0;
            bus.tx_cd    <= 1'b0;
            bus.tx_ready <= 1'b0;
            bus.addr_rd  <= 5'd0;
            bus.rd_en    <= 1'b0;
            bus.busy     <= 1'b0;
`ifdef MKIO_TX_RESP_DELAY_EN
            dly_cnt      <= 8'd0;
`endif
        end else if (bus.start) begin
            state        <= DECODE;
            cmd_ok       <= cmd_match;
            me           <= bus.p_error;
            n_words      <= cmd_words;
            word_cnt     <= 6'd0;
            bus.tx_ready <= 1'b0;
            bus.rd_en    <= 1'b0;
            bus.busy     <= cmd_match;
        end else begin
            case (state)
                IDLE: begin
                    bus.tx_ready <= 1'b0;
                    bus.rd_en    <= 1'b0;
                end
                DECODE: begin
                    if (!cmd_ok) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
`ifdef MKIO_TX_RESP_DELAY_EN
                        if (RESP_DELAY == 0) begin
                            state <= LOAD_SW;
                        end else begin
                            dly_cnt <= 8'd0;
                            state   <= DELAY;
                        end
`else
                        state <= LOAD_SW;
`endif
                    end
                end
`ifdef MKIO_TX_RESP_DELAY_EN
                DELAY: begin
                    if (dly_cnt == 8'(RESP_DELAY - 1)) begin
                        state <= LOAD_SW;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
`endif
                LOAD_SW: begin
                    bus.tx_data  <= {ADDRESS, me, 10'd0};
                    bus.tx_cd    <= 1'b0;
                    bus.tx_ready <= 1'b1;
                    state        <= PULSE;
                end
                PULSE: begin
                    bus.tx_ready <= 1'b0;
                    state        <= GUARD;
                end
                GUARD: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (!bus.tx_busy) begin
                        if (me || (word_cnt == n_words)) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.rd_en   <= 1'b1;
                            bus.addr_rd <= word_cnt[4:0];
                            state       <= RD_MEM;
                        end
                    end
                end
                RD_MEM: begin
                    bus.rd_en <= 1'b0;
                    state     <= LOAD_DW;
                end
                LOAD_DW: begin
                    bus.tx_data  <= bus.mem_data;
                    bus.tx_cd    <= 1'b1;
                    bus.tx_ready <= 1'b1;
                    word_cnt     <= word_cnt + 6'd1;
                    state        <= PULSE;
                end
                default: begin
                    state        <= IDLE;
                    bus.tx_ready <= 1'b0;
                    bus.rd_en    <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mkio_rt_tx.sv
// Self-checking bench for mkio_rt_tx: scoreboard of expected encoder words,
// an encoder model busy ENC_LEN cycles per word and a 1-cycle-latency memory.
module tb_mkio_rt_tx;

    localparam logic [4:0] RT_ADDR  = 5'd1;
    localparam int         ENC_LEN  = 20;
`ifdef MKIO_TX_RESP_DELAY_EN
    localparam int         SW_LAT   = 11;
`else
    localparam int         SW_LAT   = 3;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mkio_rt_tx_if bus();

    mkio_rt_tx #(
        .ADDRESS    (RT_ADDR),
        .RESP_DELAY (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [16:0] exp_q[$];
    logic [15:0] mem [32];
    logic [5:0]  enc_cnt;
    int          pulse_cnt    = 0;
    int          rd_cnt       = 0;
    int          busy_cycles  = 0;
    logic [4:0]  last_rd_addr = 5'd0;
    logic        prev_ready   = 1'b0;

    // Encoder model: busy for ENC_LEN cycles starting the cycle after tx_ready.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_cnt <= 6'd0;
        end else if (bus.tx_ready) begin
            enc_cnt <= 6'(ENC_LEN);
        end else if (enc_cnt != 6'd0) begin
            enc_cnt <= enc_cnt - 6'd1;
        end
    end

    assign bus.tx_busy = (enc_cnt != 6'd0);

    // RT memory model: read data valid one clock after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.mem_data <= mem[bus.addr_rd];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor: every tx_ready pulse is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [31:0] exp_word;
        if (!reset) begin
            if (bus.tx_ready) begin
                pulse_cnt <= pulse_cnt + 1;
                checkOutput("tx_ready_width", {31'd0, prev_ready}, 32'd0);
                if (exp_q.size() > 0) begin
                    exp_word = {15'd0, exp_q.pop_front()};
                end else begin
                    exp_word = 'x;
                end
                checkOutput("tx_word", {15'd0, bus.tx_cd, bus.tx_data}, exp_word);
            end
            if (bus.rd_en) begin
                rd_cnt       <= rd_cnt + 1;
                last_rd_addr <= bus.addr_rd;
            end
            if (bus.busy) begin
                busy_cycles <= busy_cycles + 1;
            end
            prev_ready <= bus.tx_ready;
        end
    end

    task automatic applyStimulus(input logic [15:0] cmd, input logic perr);
        int n;
        n = (cmd[4:0] == 5'd0) ? 32 : int'(cmd[4:0]);
        if ((cmd[15:11] == RT_ADDR) && cmd[10]) begin
            exp_q.push_back({1'b0, RT_ADDR, perr, 10'd0});
            if (!perr) begin
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back({1'b1, mem[i]});
                end
            end
        end
        bus.rx_data = cmd;
        bus.p_error = perr;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic waitPulses(input int base, input int target, input int budget);
        int n = 0;
        while ((pulse_cnt - base) < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("pulse_wait", pulse_cnt - base, target);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tx_data"},  {16'd0, bus.tx_data}, 32'd0);
        checkOutput({tag, "_tx_cd"},    {31'd0, bus.tx_cd},   32'd0);
        checkOutput({tag, "_tx_ready"}, {31'd0, bus.tx_ready}, 32'd0);
        checkOutput({tag, "_addr_rd"},  {27'd0, bus.addr_rd}, 32'd0);
        checkOutput({tag, "_rd_en"},    {31'd0, bus.rd_en},   32'd0);
        checkOutput({tag, "_busy"},     {31'd0, bus.busy},    32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_p, base_r, base_b, lat;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.rx_data = 16'd0;
        bus.p_error = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 16'h1234 + 16'(i) * 16'h0101;
        end
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic N=3 transmit with latency measurement.
        base_p = pulse_cnt;
        base_r = rd_cnt;
        applyStimulus(16'h0C43, 1'b0);
        lat = 1;
        while (!bus.tx_ready && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("sw_latency", lat, SW_LAT);
        waitDone("n3_done", 500);
        checkOutput("n3_pulses", pulse_cnt - base_p, 4);
        checkOutput("n3_reads", rd_cnt - base_r, 3);
        checkOutput("n3_queue", exp_q.size(), 0);
        checkOutput("n3_hold_data", {16'd0, bus.tx_data}, {16'd0, mem[2]});
        checkOutput("n3_hold_cd", {31'd0, bus.tx_cd}, 32'd1);

        // N=0 means 32 words.
        for (int i = 0; i < 32; i++) begin
            mem[i] = 16'hA000 + 16'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        base_p = pulse_cnt;
        base_r = rd_cnt;
        applyStimulus(16'h0C40, 1'b0);
        waitDone("n32_done", 3000);
        checkOutput("n32_pulses", pulse_cnt - base_p, 33);
        checkOutput("n32_reads", rd_cnt - base_r, 32);
        checkOutput("n32_last_addr", {27'd0, last_rd_addr}, 32'd31);
        checkOutput("n32_queue", exp_q.size(), 0);

        // Parity error: status word with ME, no data words.
        repeat (3) @(posedge clk);
        #1;
        base_p = pulse_cnt;
        base_r = rd_cnt;
        applyStimulus(16'h0C43, 1'b1);
        waitDone("me_done", 500);
        checkOutput("me_pulses", pulse_cnt - base_p, 1);
        checkOutput("me_reads", rd_cnt - base_r, 0);
        checkOutput("me_queue", exp_q.size(), 0);

        // Other RT address and receive command: no response at all.
        repeat (3) @(posedge clk);
        #1;
        base_p = pulse_cnt;
        base_b = busy_cycles;
        applyStimulus(16'h1443, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(16'h0843, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("ignore_pulses", pulse_cnt - base_p, 0);
        checkOutput("ignore_busy", busy_cycles - base_b, 0);

        // Restart during the second data word.
        base_p = pulse_cnt;
        applyStimulus(16'h0C43, 1'b0);
        waitPulses(base_p, 3, 500);
        repeat (5) @(posedge clk);
        #1;
        exp_q.delete();
        base_p = pulse_cnt;
        base_r = rd_cnt;
        applyStimulus(16'h0C41, 1'b0);
        checkOutput("abort_ready_low", {31'd0, bus.tx_ready}, 32'd0);
        waitDone("abort_done", 500);
        checkOutput("abort_pulses", pulse_cnt - base_p, 2);
        checkOutput("abort_reads", rd_cnt - base_r, 1);
        checkOutput("abort_queue", exp_q.size(), 0);

        // Asynchronous reset in the middle of a data word.
        repeat (3) @(posedge clk);
        #1;
        base_p = pulse_cnt;
        applyStimulus(16'h0C43, 1'b0);
        waitPulses(base_p, 2, 500);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post_reset_busy", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mkio_rt_tx.md
Name: mkio_rt_tx

Overview:
- Transmit-side remote-terminal (RT) block for the MKIO link (GOST 26765.52 / MIL-STD-1553).
- On a transmit command word it:
  1. builds and sends the status word (SW), then
  2. reads N data words from RT memory, and
  3. hands each word to the Manchester encoder through the tx_ready/tx_busy handshake.
- It is the counterpart of the RT receive path: that path writes memory from the bus, this block reads memory onto the bus.

Parameters:
- ADDRESS, 5'd1, RT address; placed in SW[15:11] and compared against cmd[15:11].
- RESP_DELAY, 8, clock cycles between command decode and SW load; used only when MKIO_TX_RESP_DELAY_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: rx_data holds a command word.
- rx_data  in  16  command word from decoder; sampled only when start=1.
- p_error  in  1  parity error of the command word; sampled with start.
- tx_data  out  16  word to encoder.
- tx_cd  out  1  word type: 0 = status word, 1 = data word.
- tx_ready  out  1  one-cycle pulse: tx_data/tx_cd valid.
- tx_busy  in  1  encoder busy; high from the cycle after tx_ready until the word has finished on the line.
- addr_rd  out  5  memory read address.
- rd_en  out  1  memory read strobe; data on mem_data exactly 1 clk later.
- mem_data  in  16  memory read data.
- busy  out  1  high while a response is in progress.

Behaviour:
- Reset (asynchronous): state IDLE; tx_data=0, tx_cd=0, tx_ready=0, addr_rd=0, rd_en=0, busy=0; word counter=0; ME flag=0.
- Command decode, sampled on start:
  - addr = rx_data[15:11], tr = rx_data[10], n = rx_data[4:0].
  - Word count N = n, with n=0 meaning 32.
  - ME flag = p_error.
- Response rule:
  - Respond only if addr==ADDRESS and tr==1.
  - Otherwise (including broadcast addr 31) return to IDLE and keep busy=0 for the whole event.
- States:
  - IDLE: wait for start.
  - DECODE: latch fields. Go to DELAY (feature on) or LOAD_SW; go to IDLE if the command is not for this RT.
  - DELAY: count RESP_DELAY cycles, then LOAD_SW.
  - LOAD_SW: tx_data={ADDRESS, ME, 10'd0}, tx_cd=0.
  - PULSE: tx_ready=1 for exactly 1 cycle.
  - GUARD: 1 cycle with tx_busy ignored.
  - WAIT_TX: wait tx_busy==0, then:
    - go to IDLE if ME=1 (no data words sent after a message error) or all N words are sent;
    - otherwise go to RD_MEM.
  - RD_MEM: rd_en=1 with addr_rd = current word index.
  - LOAD_DW: tx_data=mem_data, tx_cd=1, then PULSE.
- Addressing: addr_rd starts at 0 and increments after each data word. For N=32 it reaches 31; the 5-bit wrap back to 0 is harmless because the count ends the transfer first.
- busy: set in the cycle after start for a valid command; cleared on entry to IDLE.
- tx_data: holds the last value in IDLE.
- tx_ready: never high for more than 1 consecutive cycle.
- Simultaneous events / restart:
  - start while busy aborts the current response: tx_ready forced 0 next cycle, new command decoded.
  - The encoder is expected to be idle when a new command arrives.
  - tx_busy stuck high stalls in WAIT_TX. There is no timeout; reset or start recovers.
- Latency (feature off):
  - start → SW tx_ready pulse = 3 cycles (DECODE, LOAD_SW, PULSE).
  - Encoder free → next data word tx_ready = 4 cycles (WAIT_TX exit, RD_MEM, LOAD_DW, PULSE).

Optional Feature:
- Macro MKIO_TX_RESP_DELAY_EN.
- Defined: the DELAY state inserts RESP_DELAY cycles before LOAD_SW, which models the required RT response gap. RESP_DELAY=0 behaves as undefined.
- Undefined: the DELAY state and its counter are absent; DECODE goes straight to LOAD_SW.

Test Plan:
- ADDRESS=1, start with rx_data=16'h0C43 (RT1, T, SA2, N=3), p_error=0, encoder model busy 20 cycles per word → SW 16'h0800 with tx_cd=0, then data words from addresses 0, 1, 2 with tx_cd=1; exactly 4 tx_ready pulses; busy falls after the last word.
- rx_data=16'h0C40 (N=0), memory[i]=16'hA000+i → 32 data words 16'hA000..16'hA01F in order; addr_rd never exceeds 31 during the transfer.
- rx_data=16'h0C43 with p_error=1 → only SW 16'h0C00 (ME set), no rd_en pulse, return to IDLE.
- rx_data=16'h1443 (RT2) and 16'h0843 (receive command) → no tx_ready, busy stays 0.
- Second start 16'h0C41 during the 2nd data word of a N=3 response → old sequence abandoned, new SW 16'h0800 plus 1 data word; reset asserted mid-word → all outputs 0 asynchronously.
- MKIO_TX_RESP_DELAY_EN defined with RESP_DELAY=8 → SW tx_ready appears at start+11 cycles (3+8), versus start+3 with the feature off.
